seq_multiplier: RTL

Parametrised iterative shift-add multiplier: one partial product per clock, WIDTH cycles per operation, unsigned or two's-complement mode selected per operation. Replaces the fixed 8x8 single-cycle-burst multiplier behind the board switch/button wrapper. Uses a start/busy/done handshake instead of a button-driven state walk. A wrapper maps sw, btnC and led onto the ports.

---
 rtl/seq_multiplier_pkg.sv | 27 ++
 rtl/seq_multiplier.sv | 111 +++++++++++
 2 files changed

// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg
// Shared definitions for the iterative shift-add multiplier.
//   state_t : controller state encoding, kept identical to the encoding
//             the board wrapper already decodes (IDLE=00, RUN=01, DONE=10).
//   clog2   : bit width needed to count 0..value-1, never less than 1.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Plain loop form so it evaluates as a constant function for any
  // legal WIDTH; a width of 1 bit is the floor so WIDTH=2 still gets a counter.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first,
// WIDTH cycles per operation, unsigned or two's-complement per operation.
// Ports:
//   clock       : system clock, rising edge
//   reset       : synchronous active-high, returns to IDLE and clears all state
//   start       : request pulse, only honoured in IDLE or DONE
//   signed_mode : 1 = two's-complement operands, sampled with start
//   a, b        : WIDTH-bit operands, sampled with start
//   busy        : high while an operation is in progress
//   done        : high while product holds a completed, unsuperseded result
//   product     : 2*WIDTH-bit result register
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_stateNext;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               w_capture;
  logic               w_last;

  // Datapath helpers. Signed operands are reduced to magnitudes so the
  // shift-add loop is always unsigned; the most-negative value negates to
  // 2^(WIDTH-1), which is still representable as a WIDTH-bit unsigned number.
  // The multiplicand register is kept pre-shifted, so the current partial
  // product is just the multiplicand when the bottom multiplier bit is set.
  always_comb begin
    w_capture = start && ((r_state == IDLE) || (r_state == DONE));
    w_last    = (r_state == RUN) && (r_cnt == LAST_BIT);
    w_magA    = (signed_mode && a[WIDTH-1]) ? -a : a;
    w_magB    = (signed_mode && b[WIDTH-1]) ? -b : b;
    w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  // Next-state logic. A start in DONE goes straight back to RUN so
  // back-to-back operations need no idle cycle; start during RUN is ignored.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start)  w_stateNext = RUN;
      RUN:     if (w_last) w_stateNext = DONE;
      DONE:    if (start)  w_stateNext = RUN;
      default: w_stateNext = IDLE;
    endcase
  end

  // State and datapath registers. The product register is only written on
  // the final bit, so partial sums are never visible and the previous result
  // holds throughout RUN. The final sum is taken from w_accNext because the
  // last partial product is added on that same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_capture) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_magA};
        r_mplier <= w_magB;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (r_state == RUN) begin
        r_acc    <= w_accNext;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_product <= r_neg ? -w_accNext : w_accNext;
        end
      end
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy    = (r_state == RUN);
    done    = (r_state == DONE);
    product = r_product;
  end

endmodule
